// File: rtl/decode.sv
// decode: RV32I decode stage.
// Decodes the instruction held by fetch and reads the 32x32 register file, which
// lives here; writeback writes into it. The result goes into the registered
// decode-to-execute bundle. A load-use hazard stalls fetch and inserts one bubble.
// Ports:
//   clk, reset                     clock, async active-high reset
//   fe_instr, fe_pc, fe_pc_r       fetch outputs (instruction, pc, wrong-path flag)
//   ex_flush                       execute redirect; squash the next bundle
//   wb_we, wb_rd, wb_data          register file write port
//   fe_stall                       combinational; fetch holds this cycle
//   de_*                           registered bundle to execute
module decode #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fe_instr,
  input  logic [31:0] fe_pc,
  input  logic        fe_pc_r,
  input  logic        ex_flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        fe_stall,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_rs1_val,
  output logic [31:0] de_rs2_val,
  output logic [31:0] de_imm,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [4:0]  de_rd,
  output logic [2:0]  de_funct3,
  output logic [3:0]  de_alu_op,
  output logic        de_src_imm,
  output logic        de_reg_we,
  output logic        de_is_load,
  output logic        de_is_store,
  output logic        de_is_branch,
  output logic        de_is_jal,
  output logic        de_is_jalr,
  output logic        de_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR  = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8,  ALU_AND  = 4'd9,  ALU_PASS_IMM = 4'd10;
  localparam logic [3:0] ALU_ADD_PC = 4'd11;

  // Register file. Entry 0 is never written and is masked on read.
  logic [31:0] regs_q [0:31];
  logic [31:0] regs_d [0:31];

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_rd != 5'd0)) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        f7_b5;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = fe_instr[6:0];
  assign rd     = fe_instr[11:7];
  assign funct3 = fe_instr[14:12];
  assign rs1    = fe_instr[19:15];
  assign rs2    = fe_instr[24:20];
  assign f7_b5  = fe_instr[30];

  always_comb begin
    if (rs1 == 5'd0)                                rs1_val = '0;
    else if (WB_BYPASS && wb_we && (wb_rd == rs1))  rs1_val = wb_data;
    else                                            rs1_val = regs_q[rs1];
    if (rs2 == 5'd0)                                rs2_val = '0;
    else if (WB_BYPASS && wb_we && (wb_rd == rs2))  rs2_val = wb_data;
    else                                            rs2_val = regs_q[rs2];
  end

  // funct3 to ALU op; SUB only exists for register-register forms.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic b5, input logic is_reg);
    case (f3)
      3'd0:    alu_f3 = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_f3 = ALU_SLL;
      3'd2:    alu_f3 = ALU_SLT;
      3'd3:    alu_f3 = ALU_SLTU;
      3'd4:    alu_f3 = ALU_XOR;
      3'd5:    alu_f3 = b5 ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction

  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        src_imm, writes_rd, is_load, is_store, is_branch, is_jal, is_jalr, illegal;
  logic        uses_rs1, uses_rs2;

  always_comb begin
    imm       = '0;
    alu_op    = ALU_ADD;
    src_imm   = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    illegal   = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op = alu_f3(funct3, f7_b5, 1'b1); writes_rd = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        imm = {{20{fe_instr[31]}}, fe_instr[31:20]};
        alu_op = alu_f3(funct3, f7_b5, 1'b0); src_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        imm = {{20{fe_instr[31]}}, fe_instr[31:20]};
        src_imm = 1'b1; writes_rd = 1'b1; is_load = 1'b1;
      end
      OPC_STORE: begin
        imm = {{20{fe_instr[31]}}, fe_instr[31:25], fe_instr[11:7]};
        src_imm = 1'b1; is_store = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm = {{19{fe_instr[31]}}, fe_instr[31], fe_instr[7], fe_instr[30:25], fe_instr[11:8], 1'b0};
        alu_op = ALU_SUB; is_branch = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LUI: begin
        imm = {fe_instr[31:12], 12'b0};
        alu_op = ALU_PASS_IMM; src_imm = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        imm = {fe_instr[31:12], 12'b0};
        alu_op = ALU_ADD_PC; src_imm = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        // ALU forms the target pc + imm; the link value is computed in execute.
        imm = {{11{fe_instr[31]}}, fe_instr[31], fe_instr[19:12], fe_instr[20], fe_instr[30:21], 1'b0};
        alu_op = ALU_ADD_PC; src_imm = 1'b1; writes_rd = 1'b1; is_jal = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JALR: begin
        imm = {{20{fe_instr[31]}}, fe_instr[31:20]};
        src_imm = 1'b1; writes_rd = 1'b1; is_jalr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  logic de_valid_q, de_valid_d, de_is_load_q, de_is_load_d;
  logic [4:0] de_rd_q, de_rd_d;
  logic hazard, squash, bubble;

  assign hazard = de_valid_q && de_is_load_q && (de_rd_q != 5'd0) &&
                  ((uses_rs1 && (rs1 == de_rd_q)) || (uses_rs2 && (rs2 == de_rd_q)));
  assign squash = ex_flush || fe_pc_r;
  // A squashed instruction is wrong-path, so holding fetch for it is pointless.
  assign fe_stall = hazard && !squash;
  assign bubble   = hazard || squash;

  logic [31:0] de_pc_q, de_pc_d, de_rs1_val_q, de_rs1_val_d, de_rs2_val_q, de_rs2_val_d;
  logic [31:0] de_imm_q, de_imm_d;
  logic [4:0]  de_rs1_q, de_rs1_d, de_rs2_q, de_rs2_d;
  logic [2:0]  de_funct3_q, de_funct3_d;
  logic [3:0]  de_alu_op_q, de_alu_op_d;
  logic        de_src_imm_q, de_src_imm_d, de_reg_we_q, de_reg_we_d;
  logic        de_is_store_q, de_is_store_d, de_is_branch_q, de_is_branch_d;
  logic        de_is_jal_q, de_is_jal_d, de_is_jalr_q, de_is_jalr_d, de_illegal_q, de_illegal_d;

  always_comb begin
    de_pc_d        = fe_pc;
    de_rs1_val_d   = rs1_val;
    de_rs2_val_d   = rs2_val;
    de_imm_d       = imm;
    de_rs1_d       = rs1;
    de_rs2_d       = rs2;
    de_rd_d        = rd;
    de_funct3_d    = funct3;
    de_alu_op_d    = alu_op;
    de_src_imm_d   = src_imm;
    de_valid_d     = !bubble;
    de_reg_we_d    = !bubble && writes_rd && (rd != 5'd0);
    de_is_load_d   = !bubble && is_load;
    de_is_store_d  = !bubble && is_store;
    de_is_branch_d = !bubble && is_branch;
    de_is_jal_d    = !bubble && is_jal;
    de_is_jalr_d   = !bubble && is_jalr;
    de_illegal_d   = !bubble && illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_valid_q <= 1'b0;    de_pc_q <= RESET_PC;   de_rs1_val_q <= '0;   de_rs2_val_q <= '0;
      de_imm_q <= '0;        de_rs1_q <= '0;        de_rs2_q <= '0;       de_rd_q <= '0;
      de_funct3_q <= '0;     de_alu_op_q <= '0;     de_src_imm_q <= 1'b0; de_reg_we_q <= 1'b0;
      de_is_load_q <= 1'b0;  de_is_store_q <= 1'b0; de_is_branch_q <= 1'b0;
      de_is_jal_q <= 1'b0;   de_is_jalr_q <= 1'b0;  de_illegal_q <= 1'b0;
    end else begin
      de_valid_q <= de_valid_d;       de_pc_q <= de_pc_d;             de_rs1_val_q <= de_rs1_val_d;
      de_rs2_val_q <= de_rs2_val_d;   de_imm_q <= de_imm_d;           de_rs1_q <= de_rs1_d;
      de_rs2_q <= de_rs2_d;           de_rd_q <= de_rd_d;             de_funct3_q <= de_funct3_d;
      de_alu_op_q <= de_alu_op_d;     de_src_imm_q <= de_src_imm_d;   de_reg_we_q <= de_reg_we_d;
      de_is_load_q <= de_is_load_d;   de_is_store_q <= de_is_store_d; de_is_branch_q <= de_is_branch_d;
      de_is_jal_q <= de_is_jal_d;     de_is_jalr_q <= de_is_jalr_d;   de_illegal_q <= de_illegal_d;
    end
  end

  assign de_valid = de_valid_q;     assign de_pc = de_pc_q;         assign de_rs1_val = de_rs1_val_q;
  assign de_rs2_val = de_rs2_val_q; assign de_imm = de_imm_q;       assign de_rs1 = de_rs1_q;
  assign de_rs2 = de_rs2_q;         assign de_rd = de_rd_q;         assign de_funct3 = de_funct3_q;
  assign de_alu_op = de_alu_op_q;   assign de_src_imm = de_src_imm_q; assign de_reg_we = de_reg_we_q;
  assign de_is_load = de_is_load_q; assign de_is_store = de_is_store_q; assign de_is_branch = de_is_branch_q;
  assign de_is_jal = de_is_jal_q;   assign de_is_jalr = de_is_jalr_q; assign de_illegal = de_illegal_q;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed, table-driven bench for the decode stage, plus hand
// sequences for writeback bypass, load-use stall, squash and mid-stream reset.
module tb_decode;
  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fe_instr, fe_pc, wb_data;
  logic        fe_pc_r, ex_flush, wb_we;
  logic [4:0]  wb_rd;
  logic        fe_stall, de_valid, de_src_imm, de_reg_we, de_is_load, de_is_store;
  logic        de_is_branch, de_is_jal, de_is_jalr, de_illegal;
  logic [31:0] de_pc, de_rs1_val, de_rs2_val, de_imm;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [2:0]  de_funct3;
  logic [3:0]  de_alu_op;

  always #5 clk = ~clk;

  decode #(.RESET_PC(RST_PC), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .fe_instr(fe_instr), .fe_pc(fe_pc), .fe_pc_r(fe_pc_r),
    .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fe_stall(fe_stall), .de_valid(de_valid), .de_pc(de_pc), .de_rs1_val(de_rs1_val),
    .de_rs2_val(de_rs2_val), .de_imm(de_imm), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_funct3(de_funct3), .de_alu_op(de_alu_op), .de_src_imm(de_src_imm), .de_reg_we(de_reg_we),
    .de_is_load(de_is_load), .de_is_store(de_is_store), .de_is_branch(de_is_branch),
    .de_is_jal(de_is_jal), .de_is_jalr(de_is_jalr), .de_illegal(de_illegal)
  );

  // flags = {src_imm, reg_we, is_load, is_store, is_branch, is_jal, is_jalr, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs [13];
  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [7:0] dut_flags();
    return {de_src_imm, de_reg_we, de_is_load, de_is_store, de_is_branch, de_is_jal, de_is_jalr, de_illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic pc_r, input logic flush);
    fe_instr = instr; fe_pc = pc; fe_pc_r = pc_r; ex_flush = flush;
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h0050_0093, 5'd1,  32'h0000_0005, 4'd0,  8'b1100_0000}; // ADDI x1,x0,5
    vecs[1]  = '{32'hFE00_0CE3, 5'd25, 32'hFFFF_FFF8, 4'd1,  8'b0000_1000}; // BEQ -8
    vecs[2]  = '{32'h1234_53B7, 5'd7,  32'h1234_5000, 4'd10, 8'b1100_0000}; // LUI x7
    vecs[3]  = '{32'h0000_1417, 5'd8,  32'h0000_1000, 4'd11, 8'b1100_0000}; // AUIPC x8,1
    vecs[4]  = '{32'hFE31_2E23, 5'd28, 32'hFFFF_FFFC, 4'd0,  8'b1001_0000}; // SW x3,-4(x2)
    vecs[5]  = '{32'h4020_84B3, 5'd9,  32'h0000_0000, 4'd1,  8'b0100_0000}; // SUB x9,x1,x2
    vecs[6]  = '{32'h4030_D513, 5'd10, 32'h0000_0403, 4'd7,  8'b1100_0000}; // SRAI x10,x1,3
    vecs[7]  = '{32'h0100_00EF, 5'd1,  32'h0000_0010, 4'd11, 8'b1100_0100}; // JAL x1,+16
    vecs[8]  = '{32'h0000_8067, 5'd0,  32'h0000_0000, 4'd0,  8'b1000_0010}; // JALR x0,0(x1)
    vecs[9]  = '{32'h0001_2283, 5'd5,  32'h0000_0000, 4'd0,  8'b1110_0000}; // LW x5,0(x2)
    vecs[10] = '{32'h0000_0013, 5'd0,  32'h0000_0000, 4'd0,  8'b1000_0000}; // ADDI x0,x0,0
    vecs[11] = '{32'h0000_007F, 5'd0,  32'h0000_0000, 4'd0,  8'b0000_0001}; // opcode 0x7F
    vecs[12] = '{32'h0020_F5B3, 5'd11, 32'h0000_0000, 4'd9,  8'b0100_0000}; // AND x11,x1,x2

    reset = 1'b1; fe_instr = '0; fe_pc = '0; fe_pc_r = 1'b0; ex_flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(de_valid), 32'd0);
    chk("rst_pc", de_pc, RST_PC);
    chk("rst_flags", 32'(dut_flags()), 32'd0);
    chk("rst_stall", 32'(fe_stall), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      present(vecs[i].instr, 32'(32'h100 + 4 * i), 1'b0, 1'b0);
      chk($sformatf("v%0d_stall", i), 32'(fe_stall), 32'd0);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(de_valid), 32'd1);
      chk($sformatf("v%0d_pc", i), de_pc, 32'(32'h100 + 4 * i));
      chk($sformatf("v%0d_rd", i), 32'(de_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_imm", i), de_imm, vecs[i].imm);
      chk($sformatf("v%0d_alu", i), 32'(de_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_flags", i), 32'(dut_flags()), 32'(vecs[i].flags));
    end

    // Writeback bypass: x3 written while ADD x4,x3,x3 reads it.
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    present(32'h0031_8233, 32'h200, 1'b0, 1'b0);
    tick();
    chk("byp_rs1", de_rs1_val, 32'hDEAD_BEEF);
    chk("byp_rs2", de_rs2_val, 32'hDEAD_BEEF);
    wb_we = 1'b0;
    present(32'h0031_8233, 32'h204, 1'b0, 1'b0);
    tick();
    chk("x3_stored", de_rs1_val, 32'hDEAD_BEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    present(32'h0000_0233, 32'h208, 1'b0, 1'b0);
    tick();
    chk("x0_byp", de_rs1_val, 32'd0);
    wb_we = 1'b0;
    tick();
    chk("x0_after", de_rs2_val, 32'd0);

    // Load-use on rs1: one stall, one bubble, then the ADD.
    present(32'h0001_2283, 32'h300, 1'b0, 1'b0);
    tick();
    present(32'h0012_8333, 32'h304, 1'b0, 1'b0);
    chk("lu_stall", 32'(fe_stall), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(de_valid), 32'd0);
    chk("lu_bub_flags", 32'(dut_flags() & 8'b0111_1111), 32'd0);
    chk("lu_stall_clr", 32'(fe_stall), 32'd0);
    tick();
    chk("lu_add_valid", 32'(de_valid), 32'd1);
    chk("lu_add_rd", 32'(de_rd), 32'd6);
    chk("lu_add_pc", de_pc, 32'h304);

    // Load followed by an independent ADD: no stall.
    present(32'h0001_2283, 32'h310, 1'b0, 1'b0);
    tick();
    present(32'h0070_8333, 32'h314, 1'b0, 1'b0);
    chk("nolu_stall", 32'(fe_stall), 32'd0);
    tick();
    chk("nolu_valid", 32'(de_valid), 32'd1);

    // Load-use through a store's rs2.
    present(32'h0001_2283, 32'h320, 1'b0, 1'b0);
    tick();
    present(32'h0051_2023, 32'h324, 1'b0, 1'b0);
    chk("lu_st_stall", 32'(fe_stall), 32'd1);
    tick();
    chk("lu_st_bub", 32'(de_valid), 32'd0);

    // Fetch redirect squashes a good instruction.
    present(32'h0050_0093, 32'h400, 1'b1, 1'b0);
    chk("pcr_stall", 32'(fe_stall), 32'd0);
    tick();
    chk("pcr_valid", 32'(de_valid), 32'd0);
    chk("pcr_we", 32'(de_reg_we), 32'd0);

    // Execute flush during a load-use hazard wins over the stall.
    present(32'h0001_2283, 32'h410, 1'b0, 1'b0);
    tick();
    present(32'h0012_8333, 32'h414, 1'b0, 1'b1);
    chk("fl_stall", 32'(fe_stall), 32'd0);
    tick();
    chk("fl_valid", 32'(de_valid), 32'd0);
    chk("fl_flags", 32'(dut_flags() & 8'b0111_1111), 32'd0);

    // Reset mid-stream: immediate output clear and register file wiped.
    present(32'h0050_0093, 32'h500, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(de_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(de_valid), 32'd0);
    chk("mid_rst_pc", de_pc, RST_PC);
    chk("mid_rst_rd", 32'(de_rd), 32'd0);
    chk("mid_rst_flags", 32'(dut_flags()), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    present(32'h0031_8233, 32'h600, 1'b0, 1'b0);
    tick();
    chk("post_rst_x3", de_rs1_val, 32'd0);
    chk("post_rst_valid", 32'(de_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
